// File: rtl/ram_line_writer.sv
// Buffers 768-bit lines from the capture stage and streams each one to
// memory as BEATS word writes, MSB word first, under mem_ready backpressure.
// Ports: clk125/reset (async, active low); write_ram/write_data/write_address
// line input; mem_ready/mem_wr_en/mem_addr/mem_wdata word output port;
// busy, overflow (sticky drop flag), lines_written (wrapping line count).
module ram_line_writer #(
  parameter int WORD_W     = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk125,
  input  logic              reset,
  input  logic              write_ram,
  input  logic [767:0]      write_data,
  input  logic [31:0]       write_address,
  input  logic              mem_ready,
  output logic              mem_wr_en,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       lines_written
);

  localparam int LINE_W = 768;
  localparam int BEATS  = LINE_W / WORD_W;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = AW + 1;
  localparam int EW     = 32 + LINE_W;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t state, state_nx;

  logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              drop;

  logic [LINE_W-1:0] shreg;
  logic [BW-1:0]     beat;
  logic              xfer;
  logic              last;
  logic              load;
  logic              advance;
  logic              done;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign head  = fifo_mem[rd_ptr];
  // A full FIFO still takes a line when the head leaves on the same edge.
  assign push  = write_ram & (~full | pop);
  assign drop  = write_ram & full & ~pop;

  assign xfer  = mem_wr_en & mem_ready;
  assign last  = (beat == BW'(BEATS - 1));
  assign busy  = ~empty | (state == BURST);

  always_ff @(posedge clk125) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {write_address, write_data};
    end
  end

  always_ff @(posedge clk125 or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk125 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    load     = 1'b0;
    advance  = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          load     = 1'b1;
          state_nx = BURST;
        end
      end
      BURST: begin
        if (xfer) begin
          if (last) begin
            done = 1'b1;
            // Chain straight into the next line so there is no bubble.
            if (!empty) begin
              pop  = 1'b1;
              load = 1'b1;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk125 or negedge reset) begin
    if (!reset) begin
      mem_wr_en     <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      shreg         <= '0;
      beat          <= '0;
      lines_written <= '0;
    end else begin
      if (load) begin
        mem_wr_en <= 1'b1;
        mem_addr  <= head[EW-1 -: 32];
        mem_wdata <= head[LINE_W-1 -: WORD_W];
        shreg     <= head[LINE_W-1:0] << WORD_W;
        beat      <= '0;
      end else if (advance) begin
        mem_addr  <= mem_addr + 32'd1;
        mem_wdata <= shreg[LINE_W-1 -: WORD_W];
        shreg     <= shreg << WORD_W;
        beat      <= beat + BW'(1);
      end else if (done) begin
        mem_wr_en <= 1'b0;
      end
      if (done) lines_written <= lines_written + 16'd1;
    end
  end

endmodule

// File: tb/tb_ram_line_writer.sv
// Scoreboard bench for ram_line_writer: expected words are queued per
// strobe and matched against every memory transfer.
module tb_ram_line_writer;

  localparam int BEATS = 12;

  logic         clk125;
  logic         reset;
  logic         write_ram;
  logic [767:0] write_data;
  logic [31:0]  write_address;
  logic         mem_ready;
  logic         mem_wr_en;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic         busy;
  logic         overflow;
  logic [15:0]  lines_written;

  ram_line_writer dut (
    .clk125        (clk125),
    .reset         (reset),
    .write_ram     (write_ram),
    .write_data    (write_data),
    .write_address (write_address),
    .mem_ready     (mem_ready),
    .mem_wr_en     (mem_wr_en),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .busy          (busy),
    .overflow      (overflow),
    .lines_written (lines_written)
  );

  initial clk125 = 1'b0;
  always #4 clk125 = ~clk125;

  int n_checks = 0;
  int n_fail   = 0;
  int xfers    = 0;
  int exp_lines = 0;
  logic [95:0] sb[$];

  logic        prev_stall = 1'b0;
  logic [95:0] prev_word;

  function automatic logic [767:0] make_line(input logic [7:0] seed);
    logic [767:0] d;
    for (int i = 0; i < 96; i++) d[767-8*i -: 8] = seed + 8'(i);
    return d;
  endfunction

  function automatic void push_exp(input logic [31:0] a,
                                   input logic [767:0] d);
    for (int k = 0; k < BEATS; k++)
      sb.push_back({a + 32'(k), d[767-64*k -: 64]});
  endfunction

  // Transfer monitor: sampled mid-cycle, a transfer happens at the next edge.
  always @(negedge clk125) begin
    logic [95:0] e;
    if (reset && prev_stall) begin
      n_checks++;
      if ({mem_addr, mem_wdata} !== prev_word || !mem_wr_en) begin
        n_fail++;
        $display("FAIL hold_stable: got %h/%b required %h/1",
                 {mem_addr, mem_wdata}, mem_wr_en, prev_word);
      end
    end
    if (reset && mem_wr_en && mem_ready) begin
      xfers++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got %h/%h required none",
                 mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          n_fail++;
          $display("FAIL word: got %h/%h required %h/%h",
                   mem_addr, mem_wdata, e[95:64], e[63:0]);
        end
      end
    end
    prev_stall = reset && mem_wr_en && !mem_ready;
    prev_word  = {mem_addr, mem_wdata};
  end

  task automatic strobe(input logic [31:0] a, input logic [767:0] d,
                        input bit accept);
    write_ram     = 1'b1;
    write_address = a;
    write_data    = d;
    if (accept) push_exp(a, d);
    @(posedge clk125); #1;
    write_ram = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk125); #1;
      if (!busy && !mem_wr_en && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_run(output int n);
    n = 0;
    while (mem_wr_en && n < 200) begin
      n++;
      @(negedge clk125);
    end
  endtask

  task automatic wait_addr(input logic [31:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk125); #1;
      if (mem_wr_en && mem_addr == a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    write_ram = 1'b0;
    write_data = '0;
    write_address = '0;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk125);
    n_checks++;
    if ({mem_wr_en, mem_addr, mem_wdata, busy, overflow, lines_written}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b/%h/%h/%b/%b/%h required all 0",
               mem_wr_en, mem_addr, mem_wdata, busy, overflow, lines_written);
    end
    @(posedge clk125); #1;
    reset = 1'b1;
  endtask

  task automatic test_single;
    int n;
    int x0;
    bit ok;
    x0 = xfers;
    @(posedge clk125); #1;
    strobe(32'h100, make_line(8'h00), 1'b1);
    @(negedge clk125);
    n_checks++;
    if (mem_wr_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency1: got en=%b busy=%b required 0/1",
               mem_wr_en, busy);
    end
    @(negedge clk125);
    n_checks++;
    if (mem_wr_en !== 1'b1 || mem_addr !== 32'h100 ||
        mem_wdata !== 64'h0001020304050607) begin
      n_fail++;
      $display("FAIL single_first: got %b/%h/%h required 1/100/0001020304050607",
               mem_wr_en, mem_addr, mem_wdata);
    end
    count_run(n);
    n_checks++;
    if (n != BEATS) begin
      n_fail++;
      $display("FAIL single_run: got %0d required %0d", n, BEATS);
    end
    wait_idle(100, ok);
    exp_lines++;
    n_checks++;
    if (!ok || xfers - x0 != BEATS || lines_written !== 16'(exp_lines)) begin
      n_fail++;
      $display("FAIL single_done: got ok=%0d xf=%0d lw=%0d required 1/12/%0d",
               ok, xfers - x0, lines_written, exp_lines);
    end
  endtask

  task automatic test_stall;
    int x0;
    bit ok;
    bit bad;
    logic [95:0] held;
    x0 = xfers;
    bad = 1'b0;
    @(posedge clk125); #1;
    strobe(32'h100, make_line(8'h00), 1'b1);
    wait_addr(32'h103, ok);
    mem_ready = 1'b0;
    held = {mem_addr, mem_wdata};
    repeat (5) begin
      @(posedge clk125); #1;
      if ({mem_addr, mem_wdata} !== held || !mem_wr_en) bad = 1'b1;
    end
    mem_ready = 1'b1;
    n_checks++;
    if (!ok || bad) begin
      n_fail++;
      $display("FAIL stall_hold: got found=%0d moved=%0d required 1/0",
               ok, bad);
    end
    wait_idle(100, ok);
    exp_lines++;
    n_checks++;
    if (!ok || xfers - x0 != BEATS || lines_written !== 16'(exp_lines)) begin
      n_fail++;
      $display("FAIL stall_done: got ok=%0d xf=%0d lw=%0d required 1/12/%0d",
               ok, xfers - x0, lines_written, exp_lines);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    bit ok;
    @(posedge clk125); #1;
    strobe(32'h2000, make_line(8'h40), 1'b1);
    strobe(32'h3000, make_line(8'h80), 1'b1);
    @(negedge clk125);
    count_run(n);
    n_checks++;
    if (n != 2 * BEATS) begin
      n_fail++;
      $display("FAIL b2b_run: got %0d required %0d", n, 2 * BEATS);
    end
    wait_idle(100, ok);
    exp_lines += 2;
    n_checks++;
    if (!ok || lines_written !== 16'(exp_lines) || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done: got ok=%0d lw=%0d ovf=%b required 1/%0d/0",
               ok, lines_written, overflow, exp_lines);
    end
  endtask

  task automatic test_overflow;
    int x0;
    bit ok;
    x0 = xfers;
    @(posedge clk125); #1;
    mem_ready = 1'b0;
    // One line in the stalled burst plus two buffered; the fourth has no room.
    strobe(32'h4000, make_line(8'h11), 1'b1);
    strobe(32'h5000, make_line(8'h22), 1'b1);
    strobe(32'h6000, make_line(8'h33), 1'b1);
    strobe(32'h7000, make_line(8'h44), 1'b0);
    @(negedge clk125);
    n_checks++;
    if (overflow !== 1'b1 || busy !== 1'b1 || xfers != x0) begin
      n_fail++;
      $display("FAIL ovf_flag: got ovf=%b busy=%b xf=%0d required 1/1/0",
               overflow, busy, xfers - x0);
    end
    @(posedge clk125); #1;
    mem_ready = 1'b1;
    wait_idle(200, ok);
    exp_lines += 3;
    n_checks++;
    if (!ok || xfers - x0 != 3 * BEATS || lines_written !== 16'(exp_lines) ||
        overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drain: got ok=%0d xf=%0d lw=%0d ovf=%b required 1/36/%0d/1",
               ok, xfers - x0, lines_written, overflow, exp_lines);
    end
  endtask

  task automatic test_wrap;
    int x0;
    bit ok;
    logic [7:0] s;
    x0 = xfers;
    s = 8'($urandom_range(0, 255));
    @(posedge clk125); #1;
    strobe(32'hFFFF_FFFA, make_line(s), 1'b1);
    wait_idle(100, ok);
    exp_lines++;
    n_checks++;
    if (!ok || xfers - x0 != BEATS || lines_written !== 16'(exp_lines)) begin
      n_fail++;
      $display("FAIL wrap_done: got ok=%0d xf=%0d lw=%0d required 1/12/%0d",
               ok, xfers - x0, lines_written, exp_lines);
    end
  endtask

  task automatic test_reset_mid;
    int x0;
    int n;
    bit ok;
    @(posedge clk125); #1;
    strobe(32'h9000, make_line(8'h5A), 1'b1);
    wait_addr(32'h9006, ok);
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (!ok || mem_wr_en !== 1'b0 || busy !== 1'b0 ||
        lines_written !== 16'd0 || mem_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got found=%0d en=%b busy=%b lw=%0d a=%h required 1/0/0/0/0",
               ok, mem_wr_en, busy, lines_written, mem_addr);
    end
    sb.delete();
    exp_lines = 0;
    repeat (2) @(posedge clk125);
    #1;
    reset = 1'b1;
    x0 = xfers;
    @(posedge clk125); #1;
    strobe(32'hA000, make_line(8'hC3), 1'b1);
    @(negedge clk125);
    @(negedge clk125);
    count_run(n);
    n_checks++;
    if (n != BEATS) begin
      n_fail++;
      $display("FAIL reset_rerun: got %0d required %0d", n, BEATS);
    end
    wait_idle(100, ok);
    exp_lines++;
    n_checks++;
    if (!ok || xfers - x0 != BEATS || lines_written !== 16'(exp_lines) ||
        overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after: got ok=%0d xf=%0d lw=%0d ovf=%b required 1/12/%0d/0",
               ok, xfers - x0, lines_written, overflow, exp_lines);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_stall;
    test_back_to_back;
    test_overflow;
    test_wrap;
    test_reset_mid;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d words required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
